// File: rtl/instr_boot_loader.sv
`timescale 1ns/1ps
// instr_boot_loader: zero-fills the instruction memory, streams a program into it
// over a valid/ready link, then releases the downstream CPU from reset.
module instr_boot_loader #(
  parameter int IM_WORDS = 64,
  parameter int IM_AW    = 6
) (
  input  logic           clk_i,
  input  logic           rst_n,
  input  logic           restart_i,
  input  logic           load_valid_i,
  input  logic [31:0]    load_data_i,
  input  logic           load_last_i,
  output logic           load_ready_o,
  output logic           im_we_o,
  output logic [31:0]    im_addr_o,
  output logic [31:0]    im_wdata_o,
  output logic           cpu_rst_n_o,
  output logic           done_o,
  output logic           err_o,
  output logic [IM_AW:0] word_count_o
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [IM_AW-1:0] LP_LAST_IDX = IM_AW'(IM_WORDS - 1);
  localparam logic [IM_AW:0]   LP_FULL     = (IM_AW + 1)'(IM_WORDS);

  state_t           r_state;
  logic [IM_AW-1:0] r_clr_idx;
  logic [IM_AW:0]   r_word_count;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_cpu_rst_n;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic             w_full;
  logic [31:0]      w_clr_addr;
  logic [31:0]      w_cnt_addr;

  // Handshake: a word transfers on a rising edge where load_valid_i and
  // load_ready_o are both high; ready depends only on state, never on valid.
  assign load_ready_o = (r_state == ST_LOAD);
  assign w_xfer       = load_valid_i && load_ready_o;
  assign w_full       = (r_word_count == LP_FULL);
  assign w_clr_addr   = {{(30 - IM_AW){1'b0}}, r_clr_idx, 2'b00};
  assign w_cnt_addr   = {{(29 - IM_AW){1'b0}}, r_word_count, 2'b00};

  assign im_we_o      = r_we;
  assign im_addr_o    = r_addr;
  assign im_wdata_o   = r_wdata;
  assign cpu_rst_n_o  = r_cpu_rst_n;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign word_count_o = r_word_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state      <= ST_CLEAR;
      r_clr_idx    <= '0;
      r_word_count <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_we    <= 1'b1;
          r_addr  <= w_clr_addr;
          r_wdata <= '0;
          if (r_clr_idx == LP_LAST_IDX) begin
            r_state <= ST_LOAD;
          end else begin
            r_clr_idx <= r_clr_idx + IM_AW'(1);
          end
        end
        ST_LOAD: begin
          r_we <= 1'b0;
          if (w_xfer) begin
            // A word beyond capacity is an overflow even if it claims to be last.
            if (w_full) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_we         <= 1'b1;
              r_addr       <= w_cnt_addr;
              r_wdata      <= load_data_i;
              r_word_count <= r_word_count + (IM_AW + 1)'(1);
              if (load_last_i) begin
                r_state <= ST_RUN;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          r_we <= 1'b0;
          if (restart_i) begin
            r_state      <= ST_CLEAR;
            r_clr_idx    <= '0;
            r_word_count <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
          end else begin
            // Lags RUN entry by one cycle so the final write lands first.
            r_cpu_rst_n <= 1'b1;
          end
        end
        ST_ERROR: begin
          r_we        <= 1'b0;
          r_cpu_rst_n <= 1'b0;
          if (restart_i) begin
            r_state      <= ST_CLEAR;
            r_clr_idx    <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_boot_loader.sv
`timescale 1ns/1ps
// Bench for instr_boot_loader: directed phases with random data and gaps, a
// transaction-level model of the expected memory writes, and a write monitor.
module tb_instr_boot_loader;

  localparam int IM_WORDS = 64;
  localparam int IM_AW    = 6;

  logic           clk_i;
  logic           rst_n;
  logic           restart_i;
  logic           load_valid_i;
  logic [31:0]    load_data_i;
  logic           load_last_i;
  logic           load_ready_o;
  logic           im_we_o;
  logic [31:0]    im_addr_o;
  logic [31:0]    im_wdata_o;
  logic           cpu_rst_n_o;
  logic           done_o;
  logic           err_o;
  logic [IM_AW:0] word_count_o;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] src_q[$];
  int          m_count;
  bit          m_run;
  bit          m_err;

  instr_boot_loader #(.IM_WORDS(IM_WORDS), .IM_AW(IM_AW)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .restart_i    (restart_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_wdata_o   (im_wdata_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_count_o (word_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk_i) begin
    if (im_we_o === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", im_addr_o, e[63:32]);
        chk("write_data", im_wdata_o, e[31:0]);
      end
    end
  end

  function automatic void model_reset();
    m_count = 0;
    m_run   = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_xfer(input logic [31:0] d, input logic last);
    if (m_count >= IM_WORDS) begin
      m_err = 1'b1;
    end else begin
      exp_q.push_back({32'(m_count * 4), d});
      m_count++;
      if (last) m_run = 1'b1;
    end
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, im_we_o, 32'd0);
    chk({tag, "_addr"}, im_addr_o, 32'd0);
    chk({tag, "_wdata"}, im_wdata_o, 32'd0);
    chk({tag, "_cpu_rst"}, cpu_rst_n_o, 32'd0);
    chk({tag, "_done"}, done_o, 32'd0);
    chk({tag, "_err"}, err_o, 32'd0);
    chk({tag, "_ready"}, load_ready_o, 32'd0);
    chk({tag, "_count"}, word_count_o, 32'd0);
  endtask

  task automatic do_sweep(input bit poke_restart);
    int n;
    for (int k = 0; k < IM_WORDS; k++) exp_q.push_back({32'(k * 4), 32'h0});
    n = 0;
    while (load_ready_o !== 1'b1 && n < 200) begin
      restart_i = poke_restart && (n == 10);
      step();
      n++;
    end
    restart_i = 1'b0;
    chk("sweep_len", 32'(n), 32'(IM_WORDS));
    chk("sweep_cpu_rst", cpu_rst_n_o, 32'd0);
    chk("sweep_count", word_count_o, 32'd0);
    @(negedge clk_i);
    #1;
    chk("sweep_writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_words(input int n, input bit with_last, input int gap_max);
    logic [31:0] d;
    int g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, gap_max);
      for (int j = 0; j < g; j++) begin
        load_valid_i = 1'b0;
        load_last_i  = 1'($urandom_range(0, 1));
        load_data_i  = $urandom;
        step();
      end
      if (src_q.size() != 0) d = src_q.pop_front();
      else d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      load_valid_i = 1'b1;
      load_data_i  = d;
      load_last_i  = with_last && (i == n - 1);
      if (load_ready_o === 1'b1) model_xfer(d, load_last_i);
      step();
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_done"}, done_o, 32'(m_run));
    chk({tag, "_ready"}, load_ready_o, 32'd0);
    chk({tag, "_count"}, word_count_o, 32'(m_count));
    chk({tag, "_cpu_rst_held"}, cpu_rst_n_o, 32'd0);
    load_valid_i = 1'b1;
    load_data_i  = $urandom;
    step();
    chk({tag, "_cpu_rst_rel"}, cpu_rst_n_o, 32'd1);
    repeat (3) step();
    load_valid_i = 1'b0;
    chk({tag, "_done_hold"}, done_o, 32'd1);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart(input string tag);
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    chk({tag, "_cpu_rst"}, cpu_rst_n_o, 32'd0);
    chk({tag, "_done"}, done_o, 32'd0);
    chk({tag, "_err"}, err_o, 32'd0);
    chk({tag, "_count"}, word_count_o, 32'd0);
    chk({tag, "_we"}, im_we_o, 32'd0);
    model_reset();
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    restart_i    = 1'b0;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    load_last_i  = 1'b0;
    model_reset();

    repeat (2) step();
    check_reset_values("reset");
    rst_n = 1'b1;
    do_sweep(1'b0);

    src_q = '{32'h20010005, 32'h20020003, 32'h00221820};
    load_words(3, 1'b1, 0);
    check_run("run3");

    do_restart("rst_run3");
    do_sweep(1'b1);
    load_words(2, 1'b1, 3);
    check_run("gap2");

    do_restart("rst_gap2");
    do_sweep(1'b0);
    load_words(1, 1'b1, 2);
    check_run("reload1");

    do_restart("rst_reload1");
    do_sweep(1'b0);
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    chk("load_restart_ignored_ready", load_ready_o, 32'd1);
    chk("load_restart_ignored_count", word_count_o, 32'd0);

    load_words(IM_WORDS + 1, 1'b0, 1);
    chk("ovf_err", err_o, 32'(m_err));
    chk("ovf_ready", load_ready_o, 32'd0);
    chk("ovf_count", word_count_o, 32'(m_count));
    chk("ovf_cpu_rst", cpu_rst_n_o, 32'd0);
    chk("ovf_done", done_o, 32'd0);
    load_valid_i = 1'b1;
    load_last_i  = 1'b1;
    repeat (3) step();
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    chk("ovf_err_hold", err_o, 32'd1);
    chk("ovf_writes_left", 32'(exp_q.size()), 32'd0);
    do_restart("rst_ovf");
    do_sweep(1'b0);

    load_words(5, 1'b0, 1);
    chk("midload_count", word_count_o, 32'(m_count));
    rst_n = 1'b0;
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    chk("midload_writes_left", 32'(exp_q.size()), 32'd0);
    check_reset_values("midload_rst");
    model_reset();
    rst_n = 1'b1;
    do_sweep(1'b0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < IM_WORDS; i++) exp_q.push_back({32'(i * 4), 32'h0});
    k = $urandom_range(3, 40);
    repeat (k) step();
    rst_n = 1'b0;
    step();
    chk("midclear_consumed", 32'(exp_q.size()), 32'(IM_WORDS - k));
    exp_q.delete();
    check_reset_values("midclear_rst");
    rst_n = 1'b1;
    do_sweep(1'b0);

    load_words(4, 1'b1, 2);
    check_run("final4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_boot_loader.md
Name: instr_boot_loader

Overview:
- Program loader that sits directly upstream of Simple_Single_CPU.
- Receives a program as a stream of 32-bit instruction words over a valid/ready handshake and writes them into the instruction memory write port.
- Holds the CPU in reset until the program is fully loaded, then releases it.
- Before loading, clears every instruction memory word to zero, so an all-zero word terminates execution after the program end.

Parameters:
- IM_WORDS, 64, number of 32-bit words in instruction memory.
- IM_AW, 6, word-index width; must satisfy 2**IM_AW >= IM_WORDS.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- restart_i  in  1  single-cycle pulse; honoured only in RUN or ERROR.
- load_valid_i  in  1  upstream word valid.
- load_data_i  in  32  instruction word.
- load_last_i  in  1  marks final word of program; qualified by valid.
- load_ready_o  out  1  loader accepts a word this cycle.
- im_we_o  out  1  instruction memory write enable.
- im_addr_o  out  32  byte address for write, word aligned (index*4).
- im_wdata_o  out  32  write data.
- cpu_rst_n_o  out  1  active-low reset to the CPU (drives rst_n of Simple_Single_CPU).
- done_o  out  1  high in RUN.
- err_o  out  1  high in ERROR (program overflow).
- word_count_o  out  IM_AW+1  number of words accepted in current load.

Behaviour:
- Reset, clock and reset: one clock clk_i; rst_n is synchronous, active-low.
- While rst_n=0 at a rising edge:
  - state goes to CLEAR with clear index 0 and word_count_o=0.
  - im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_rst_n_o=0, done_o=0, err_o=0, load_ready_o=0.
- All outputs are registered except load_ready_o, which is decoded from state (1 only in LOAD).
- CLEAR:
  - Each cycle writes zero to word index k, with im_we_o=1, im_addr_o=k*4, im_wdata_o=0, for k=0..IM_WORDS-1.
  - Registered outputs appear the cycle after the state edge; the sweep takes exactly IM_WORDS write cycles.
  - After index IM_WORDS-1 is issued, go to LOAD. word_count_o is held at 0.
- LOAD:
  - A transfer occurs on a rising edge with load_valid_i=1 and load_ready_o=1.
  - On transfer with word_count_o < IM_WORDS: next cycle drives im_we_o=1, im_addr_o=word_count_o*4, im_wdata_o=load_data_i; word_count_o increments.
  - No transfer: im_we_o=0 next cycle; address and data hold.
  - Transfer with load_last_i=1 (and no overflow): write performed as above; state goes to RUN.
  - Transfer when word_count_o == IM_WORDS: no write, state goes to ERROR, word_count_o unchanged. The overflow check takes priority over load_last_i.
  - load_data_i=0 is a legal word and is written normally.
  - load_last_i without load_valid_i is ignored.
- RUN:
  - done_o=1 and load_ready_o=0.
  - cpu_rst_n_o=1 starting the cycle after RUN is entered, so the CPU first samples reset release one cycle after the last instruction write is visible.
  - im_we_o=0.
  - restart_i=1: go to CLEAR, cpu_rst_n_o=0 and done_o=0 on the next cycle, word_count_o cleared.
- ERROR:
  - err_o=1, cpu_rst_n_o=0, load_ready_o=0, im_we_o=0.
  - restart_i=1: go to CLEAR and clear err_o.
- restart_i in CLEAR or LOAD is ignored.
- rst_n=0 in any state, including mid-CLEAR or mid-LOAD, aborts immediately to reset values. Partial memory contents are not preserved semantics; the next CLEAR overwrites them.
- Simultaneous rst_n=0 and restart_i: reset wins.
- Addresses are word_index*4 zero-extended to 32 bits; no wrap-around. Index IM_WORDS is never written.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> 64 cycles of im_we_o=1 with addresses 0,4,…,252 and data 0; then load_ready_o=1, cpu_rst_n_o=0.
- Load 3 words 0x20010005, 0x20020003, 0x00221820 (last on the third), valid every cycle -> writes at 0,4,8 one cycle after each transfer; done_o=1; cpu_rst_n_o=1 the cycle after RUN is entered; word_count_o=3.
- Gaps and backpressure: valid toggles 1,0,0,1 with last on the second word -> exactly 2 writes at 0 and 4, no write in idle cycles, no stray writes after RUN.
- Overflow: 65 words, no last -> 64 writes (0..252); the 65th transfer asserts err_o=1, no write, cpu_rst_n_o stays 0; restart_i -> CLEAR sweep, err_o=0.
- Restart from RUN: after a 2-word load, pulse restart_i -> cpu_rst_n_o=0 next cycle, full zero sweep, word_count_o=0, then reload of 1 word goes to address 0.
- Reset mid-LOAD after 5 words -> all outputs at reset values; a new CLEAR sweep follows; a subsequent load starts at address 0.
